// File: rtl/frame_sequencer.sv
// Sequences SPI load strobes through a display ROM: driver setup words once, then
// bitmap frames column by column with a pause after each frame, once or looping.
module frame_sequencer #(
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned SETUP_N = 4,
    parameter int unsigned COLS    = 8,
    parameter int unsigned FRAMES  = 2,
    parameter int unsigned GAP     = 63,
    parameter int unsigned PAUSE_W = 22
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          enable,
    input  logic                                          spi_ready,
    input  logic                                          mode_loop,
    input  logic                                          skip,
    input  logic [PAUSE_W-1:0]                            pause_len,
    output logic [ADDR_W-1:0]                             address,
    output logic                                          spi_load,
    output logic [((FRAMES > 1) ? $clog2(FRAMES) : 1)-1:0] frame_idx,
    output logic                                          done
);

    localparam int unsigned FI_W  = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int unsigned GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned PCW   = PAUSE_W + 1;

    localparam longint unsigned ADDR_SPAN = 64'd1 << ADDR_W;
    localparam longint unsigned ROM_USE   = 64'(SETUP_N) + 64'(FRAMES) * 64'(COLS);

    // Refuse to build when the ROM image cannot be addressed or the sequence is empty.
    if (ROM_USE > ADDR_SPAN) begin : g_rom_overflow
        $error("frame_sequencer: SETUP_N + FRAMES*COLS exceeds 2**ADDR_W");
    end
    if (SETUP_N == 0 || COLS == 0 || FRAMES == 0) begin : g_empty_sequence
        $error("frame_sequencer: SETUP_N, COLS and FRAMES must be non-zero");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_DISPLAY = 3'd2,
        S_PAUSE   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              state, state_nxt;
    logic [GAP_W-1:0]    gap_cnt, gap_nxt;
    logic [PAUSE_W-1:0]  pause_cnt, pause_nxt;
    logic [COL_W-1:0]    col, col_nxt;
    logic [ADDR_W-1:0]   next_addr, next_addr_nxt;
    logic [ADDR_W-1:0]   address_nxt;
    logic                spi_load_nxt;
    logic [FI_W-1:0]     frame_nxt;
    logic                done_nxt;

    logic                gap_sat;
    logic                issue;
    logic                last_setup;
    logic                last_col;
    logic                last_frame;
    logic [PCW-1:0]      pause_limit;
    logic                pause_hit;

    // Qualifiers shared by the next-state logic.
    always_comb begin
        gap_sat     = (gap_cnt >= GAP_W'(GAP));
        issue       = ((state == S_SETUP) || (state == S_DISPLAY)) && spi_ready
                      && gap_sat && !spi_load;
        last_setup  = (next_addr == ADDR_W'(SETUP_N - 1));
        last_col    = (col == COL_W'(COLS - 1));
        last_frame  = (frame_idx == FI_W'(FRAMES - 1));
        pause_limit = (pause_len == '0) ? PCW'(1) : {1'b0, pause_len};
        pause_hit   = (({1'b0, pause_cnt} + PCW'(1)) >= pause_limit);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt     = state;
        address_nxt   = address;
        spi_load_nxt  = 1'b0;
        frame_nxt     = frame_idx;
        done_nxt      = 1'b0;
        col_nxt       = col;
        next_addr_nxt = next_addr;
        pause_nxt     = pause_cnt;
        gap_nxt       = gap_sat ? GAP_W'(GAP) : gap_cnt + GAP_W'(1);

        if (issue) begin
            address_nxt   = next_addr;
            spi_load_nxt  = 1'b1;
            gap_nxt       = '0;
            next_addr_nxt = next_addr + ADDR_W'(1);
        end

        case (state)
            S_IDLE: begin
                if (spi_ready) begin
                    state_nxt     = S_SETUP;
                    gap_nxt       = GAP_W'(GAP);
                    next_addr_nxt = '0;
                    col_nxt       = '0;
                    frame_nxt     = '0;
                end
            end
            S_SETUP: begin
                if (issue && last_setup) begin
                    state_nxt = S_DISPLAY;
                    frame_nxt = '0;
                    col_nxt   = '0;
                end
            end
            S_DISPLAY: begin
                if (issue) begin
                    if (last_col) begin
                        state_nxt = S_PAUSE;
                        pause_nxt = '0;
                    end else begin
                        col_nxt = col + COL_W'(1);
                    end
                end
            end
            S_PAUSE: begin
                pause_nxt = pause_cnt + PAUSE_W'(1);
                if (skip || pause_hit) begin
                    col_nxt = '0;
                    if (!last_frame) begin
                        state_nxt = S_DISPLAY;
                        frame_nxt = frame_idx + FI_W'(1);
                    end else if (mode_loop) begin
                        // Loop back to the first bitmap column; setup is not replayed.
                        state_nxt     = S_DISPLAY;
                        frame_nxt     = '0;
                        next_addr_nxt = ADDR_W'(SETUP_N);
                    end else begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                done_nxt = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; dropping enable acts like reset.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            state     <= S_IDLE;
            gap_cnt   <= '0;
            pause_cnt <= '0;
            col       <= '0;
            next_addr <= '0;
            address   <= '0;
            spi_load  <= 1'b0;
            frame_idx <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            gap_cnt   <= gap_nxt;
            pause_cnt <= pause_nxt;
            col       <= col_nxt;
            next_addr <= next_addr_nxt;
            address   <= address_nxt;
            spi_load  <= spi_load_nxt;
            frame_idx <= frame_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: a sequence-position model checked every cycle against two
// instances (default and small parameters), plus directed scenarios with literal expectations.
module tb_frame_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable, spi_ready, mode_loop, skip;
    logic [21:0] pause_len;
    logic [6:0]  address;
    logic        spi_load;
    logic [0:0]  frame_idx;
    logic        done;

    logic        s_reset, s_enable, s_spi_ready, s_mode_loop, s_skip;
    logic [21:0] s_pause_len;
    logic [6:0]  s_address;
    logic        s_spi_load;
    logic [1:0]  s_frame_idx;
    logic        s_done;

    frame_sequencer dut (
        .clk(clk), .reset(reset), .enable(enable), .spi_ready(spi_ready),
        .mode_loop(mode_loop), .skip(skip), .pause_len(pause_len),
        .address(address), .spi_load(spi_load), .frame_idx(frame_idx), .done(done)
    );

    frame_sequencer #(.ADDR_W(7), .SETUP_N(2), .COLS(4), .FRAMES(3), .GAP(3), .PAUSE_W(22)) dut_s (
        .clk(clk), .reset(s_reset), .enable(s_enable), .spi_ready(s_spi_ready),
        .mode_loop(s_mode_loop), .skip(s_skip), .pause_len(s_pause_len),
        .address(s_address), .spi_load(s_spi_load), .frame_idx(s_frame_idx), .done(s_done)
    );

    // Model: pos is the next ROM word in the play list (word index == address).
    typedef struct {
        bit run;
        bit pause;
        bit fin;
        int pos;
        int since;
        int elapsed;
        int addr;
        bit load;
    } mst_t;

    typedef struct {
        int addr;
        int cyc;
        int fi;
    } pulse_t;

    mst_t   md = '{default: 0};
    mst_t   ms = '{default: 0};
    pulse_t pq_d[$];
    pulse_t pq_s[$];
    int     cyc = 0;
    int     n_pass = 0;
    int     n_total = 0;
    bit     chk_en = 1'b0;

    function automatic mst_t mstep(mst_t m, int setup_n, int cols, int frames, int gap,
                                   bit rst, bit en, bit rdy, bit loop, bit skp, int plen);
        mst_t n;
        int   total;
        n     = m;
        total = setup_n + frames * cols;
        if (rst || !en) begin
            n = '{default: 0};
            return n;
        end
        n.load  = 1'b0;
        n.since = (m.since >= gap) ? gap : m.since + 1;
        if (!m.run) begin
            if (rdy) begin
                n.run   = 1'b1;
                n.since = gap;
                n.pos   = 0;
            end
        end else if (m.fin) begin
            n.fin = 1'b1;
        end else if (m.pause) begin
            n.elapsed = m.elapsed + 1;
            if (skp || n.elapsed >= ((plen == 0) ? 1 : plen)) begin
                if (m.pos < total) begin
                    n.pause = 1'b0;
                end else if (loop) begin
                    n.pause = 1'b0;
                    n.pos   = setup_n;
                end else begin
                    n.fin = 1'b1;
                end
            end
        end else if (rdy && m.since >= gap && !m.load) begin
            n.load  = 1'b1;
            n.addr  = m.pos;
            n.since = 0;
            n.pos   = m.pos + 1;
            if (m.pos >= setup_n && ((m.pos - setup_n) % cols) == cols - 1) begin
                n.pause   = 1'b1;
                n.elapsed = 0;
            end
        end
        return n;
    endfunction

    function automatic int fexp(mst_t m, int setup_n, int cols);
        int p;
        p = (m.pause || m.fin) ? m.pos - 1 : m.pos;
        return (p < setup_n) ? 0 : (p - setup_n) / cols;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) begin
        md = mstep(md, 4, 8, 2, 63, reset, enable, spi_ready, mode_loop, skip, int'(pause_len));
        ms = mstep(ms, 2, 4, 3, 3, s_reset, s_enable, s_spi_ready, s_mode_loop, s_skip,
                   int'(s_pause_len));
        cyc++;
    end

    // Per-cycle comparison against the model, and pulse logging for the directed checks.
    always @(negedge clk) begin
        if (chk_en) begin
            check("address", int'(address), md.addr);
            check("spi_load", int'(spi_load), int'(md.load));
            check("frame_idx", int'(frame_idx), fexp(md, 4, 8));
            check("done", int'(done), int'(md.fin));
            check("s_address", int'(s_address), ms.addr);
            check("s_spi_load", int'(s_spi_load), int'(ms.load));
            check("s_frame_idx", int'(s_frame_idx), fexp(ms, 2, 4));
            check("s_done", int'(s_done), int'(ms.fin));
            if (spi_load) pq_d.push_back('{int'(address), cyc, int'(frame_idx)});
            if (s_spi_load) pq_s.push_back('{int'(s_address), cyc, int'(s_frame_idx)});
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        pq_d.delete();
    endtask

    task automatic wait_pulses(input int n, input int budget, input string name);
        int i;
        i = 0;
        while (pq_d.size() < n && i < budget) begin
            tick();
            i++;
        end
        check(name, int'(pq_d.size() >= n), 1);
    endtask

    task automatic wait_addr(input int a, input int budget, input string name);
        int i;
        i = 0;
        while (!(spi_load && int'(address) == a) && i < budget) begin
            tick();
            i++;
        end
        check(name, int'(spi_load && int'(address) == a), 1);
    endtask

    initial begin
        int i;
        int nb;
        int rc;
        int p11;
        int low;

        reset = 1'b1; enable = 1'b1; spi_ready = 1'b1; mode_loop = 1'b0; skip = 1'b0;
        pause_len = 22'd100;
        s_reset = 1'b1; s_enable = 1'b1; s_spi_ready = 1'b1; s_mode_loop = 1'b0; s_skip = 1'b0;
        s_pause_len = 22'd0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        tick();
        check("reset_address", int'(address), 0);
        check("reset_spi_load", int'(spi_load), 0);
        check("reset_done", int'(done), 0);
        check("reset_frame_idx", int'(frame_idx), 0);

        // Play once: setup, two frames with 100-cycle pauses, then done.
        do_reset();
        i = 0;
        while (!done && i < 3000) begin
            tick();
            i++;
        end
        check("once_done_reached", int'(done), 1);
        check("once_pulse_count", pq_d.size(), 20);
        for (int k = 0; k < 20; k++)
            if (k < pq_d.size()) check("once_addr", pq_d[k].addr, k);
        for (int k = 1; k < 20; k++)
            if (k < pq_d.size())
                check("once_spacing", pq_d[k].cyc - pq_d[k-1].cyc, (k == 12) ? 101 : 64);
        if (pq_d.size() > 12) check("once_frame1_idx", pq_d[12].fi, 1);
        for (int k = 0; k < 10; k++) tick();
        check("once_done_hold_addr", int'(address), 19);
        check("once_done_held", int'(done), 1);

        // Loop mode: after the last frame's pause, play resumes at address 4.
        mode_loop = 1'b1;
        do_reset();
        wait_pulses(22, 4000, "loop_pulses_reached");
        if (pq_d.size() >= 22) begin
            check("loop_wrap_addr", pq_d[20].addr, 4);
            check("loop_wrap_frame", pq_d[20].fi, 0);
            check("loop_wrap_gap", pq_d[20].cyc - pq_d[19].cyc, 101);
            check("loop_next_addr", pq_d[21].addr, 5);
        end
        low = 0;
        foreach (pq_d[k]) if (pq_d[k].addr < 4) low++;
        check("loop_setup_once", low, 4);
        mode_loop = 1'b0;

        // spi_ready stall after address 6; skip outside PAUSE is ignored.
        do_reset();
        wait_addr(6, 1000, "stall_found_addr6");
        spi_ready = 1'b0;
        nb = pq_d.size();
        for (int k = 0; k < 200; k++) begin
            skip = (k == 50);
            tick();
        end
        skip = 1'b0;
        check("stall_no_pulse", pq_d.size(), nb);
        spi_ready = 1'b1;
        rc = cyc;
        tick();
        check("stall_resume_count", pq_d.size(), nb + 1);
        if (pq_d.size() > 0) begin
            check("stall_resume_addr", pq_d[$].addr, 7);
            check("stall_resume_time", pq_d[$].cyc, rc + 1);
        end

        // Long pause cut short by skip; next word is column 0 of frame 1 once the gap allows.
        pause_len = 22'h3FFFFF;
        do_reset();
        wait_addr(11, 1500, "skip_found_addr11");
        p11 = cyc;
        for (int k = 0; k < 9; k++) tick();
        skip = 1'b1;
        tick();
        skip = 1'b0;
        nb = pq_d.size();
        wait_pulses(nb + 1, 200, "skip_next_pulse");
        if (pq_d.size() > nb) begin
            check("skip_next_addr", pq_d[nb].addr, 12);
            check("skip_next_time", pq_d[nb].cyc, p11 + 64);
            check("skip_next_frame", pq_d[nb].fi, 1);
        end
        pause_len = 22'd100;

        // Reset during frame 1 pause, then enable drop mid-display: both restart at 0.
        do_reset();
        wait_addr(19, 3000, "rst_found_addr19");
        for (int k = 0; k < 5; k++) tick();
        reset = 1'b1;
        tick();
        check("midrst_address", int'(address), 0);
        check("midrst_spi_load", int'(spi_load), 0);
        check("midrst_frame_idx", int'(frame_idx), 0);
        reset = 1'b0;
        pq_d.delete();
        wait_pulses(1, 100, "midrst_restart");
        if (pq_d.size() > 0) check("midrst_first_addr", pq_d[0].addr, 0);
        wait_addr(8, 1500, "en_found_addr8");
        enable = 1'b0;
        tick();
        check("en_drop_address", int'(address), 0);
        check("en_drop_spi_load", int'(spi_load), 0);
        enable = 1'b1;
        pq_d.delete();
        wait_pulses(1, 100, "en_restart");
        if (pq_d.size() > 0) check("en_first_addr", pq_d[0].addr, 0);

        // Small configuration: 14 words, 4-cycle spacing, 1-cycle pauses.
        s_reset = 1'b0;
        i = 0;
        while (!s_done && i < 500) begin
            tick();
            i++;
        end
        check("small_done_reached", int'(s_done), 1);
        check("small_pulse_count", pq_s.size(), 14);
        for (int k = 0; k < 14; k++)
            if (k < pq_s.size()) check("small_addr", pq_s[k].addr, k);
        for (int k = 1; k < 14; k++)
            if (k < pq_s.size()) check("small_spacing", pq_s[k].cyc - pq_s[k-1].cyc, 4);
        if (pq_s.size() > 10) check("small_frame2_idx", pq_s[10].fi, 2);
        for (int k = 0; k < 5; k++) tick();
        check("small_done_addr", int'(s_address), 13);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
